// File: rtl/ser12_tx_if.sv
// Word-in / bit-out handshake bundle for the 12-bit serializer.
// slave is the serializer's view, master is the producer/sink view.
interface ser12_tx_if;
    logic [11:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        ser_stall;
    logic        ser_out;
    logic        ser_valid;
    logic        ser_first;
    logic        ser_last;
    logic        busy;

    modport slave (
        input  in_data,
        input  in_valid,
        input  ser_stall,
        output in_ready,
        output ser_out,
        output ser_valid,
        output ser_first,
        output ser_last,
        output busy
    );

    modport master (
        output in_data,
        output in_valid,
        output ser_stall,
        input  in_ready,
        input  ser_out,
        input  ser_valid,
        input  ser_first,
        input  ser_last,
        input  busy
    );
endinterface

// File: rtl/ser12_tx.sv
// 12-bit parallel-to-serial transmitter with stall hold and
// zero-gap back-to-back word loading.
module ser12_tx #(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    ser12_tx_if.slave   bus
);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [11:0] sh;
    logic [11:0] sh_nxt;
    logic [3:0]  cnt;
    logic [3:0]  cnt_nxt;

    logic        at_last;
    logic        accept;
    logic        load;
    logic [11:0] sh_shift;

    assign at_last = (cnt == 4'd11);
    assign accept  = (state == SHIFT) && !bus.ser_stall;

    // Shift toward whichever end feeds ser_out.
    assign sh_shift = MSB_FIRST ? {sh[10:0], 1'b0}
                                : {1'b0, sh[11:1]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            sh    <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            sh    <= sh_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        sh_nxt        = sh;
        cnt_nxt       = cnt;
        load          = 1'b0;
        bus.in_ready  = 1'b0;
        bus.ser_valid = 1'b0;
        bus.ser_out   = 1'b0;
        bus.ser_first = 1'b0;
        bus.ser_last  = 1'b0;
        bus.busy      = 1'b0;

        unique case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                load         = bus.in_valid;
                if (load) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                bus.busy      = 1'b1;
                bus.ser_valid = 1'b1;
                bus.ser_out   = MSB_FIRST ? sh[11] : sh[0];
                bus.ser_first = (cnt == 4'd0);
                bus.ser_last  = at_last;
                bus.in_ready  = at_last && !bus.ser_stall;
                if (accept) begin
                    if (!at_last) begin
                        sh_nxt  = sh_shift;
                        cnt_nxt = cnt + 4'd1;
                    end else if (bus.in_valid) begin
                        load = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (load) begin
            sh_nxt  = bus.in_data;
            cnt_nxt = 4'd0;
        end
    end

endmodule

// File: tb/tb_ser12_tx.sv
// Random and directed bench for ser12_tx, both bit orders side by side,
// against an index-based word/position reference model.
module tb_ser12_tx;

    logic clk;
    logic rst;

    ser12_tx_if b0 ();
    ser12_tx_if b1 ();

    ser12_tx #(.MSB_FIRST(1'b0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (b0)
    );

    ser12_tx #(.MSB_FIRST(1'b1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (b1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_err;

    // reference model: word in flight and bit position being presented
    bit          m_busy;
    logic [11:0] m_word;
    int          m_pos;
    logic [11:0] a0;
    logic [11:0] a1;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [11:0] d,
                         input logic st);
        b0.in_valid  = v;
        b1.in_valid  = v;
        b0.in_data   = d;
        b1.in_data   = d;
        b0.ser_stall = st;
        b1.ser_stall = st;
    endtask

    task automatic check_outs(input logic st);
        logic e_rdy;
        logic e_o0;
        logic e_o1;
        e_rdy = !m_busy || (m_pos == 11 && !st);
        e_o0  = m_busy ? m_word[m_pos] : 1'b0;
        e_o1  = m_busy ? m_word[11 - m_pos] : 1'b0;
        check("rdy0",   32'(b0.in_ready),  32'(e_rdy));
        check("rdy1",   32'(b1.in_ready),  32'(e_rdy));
        check("valid0", 32'(b0.ser_valid), 32'(m_busy));
        check("valid1", 32'(b1.ser_valid), 32'(m_busy));
        check("busy0",  32'(b0.busy),      32'(m_busy));
        check("busy1",  32'(b1.busy),      32'(m_busy));
        check("out0",   32'(b0.ser_out),   32'(e_o0));
        check("out1",   32'(b1.ser_out),   32'(e_o1));
        check("first0", 32'(b0.ser_first), 32'(m_busy && m_pos == 0));
        check("first1", 32'(b1.ser_first), 32'(m_busy && m_pos == 0));
        check("last0",  32'(b0.ser_last),  32'(m_busy && m_pos == 11));
        check("last1",  32'(b1.ser_last),  32'(m_busy && m_pos == 11));
    endtask

    task automatic step(input logic v, input logic [11:0] d,
                        input logic st);
        @(negedge clk);
        drive(v, d, st);
        #1;
        check_outs(st);
        // reassemble each accepted word from the serial stream
        if (m_busy && !st) begin
            a0[m_pos]      = b0.ser_out;
            a1[11 - m_pos] = b1.ser_out;
            if (m_pos == 11) begin
                check("word0", 32'(a0), 32'(m_word));
                check("word1", 32'(a1), 32'(m_word));
            end
        end
        @(posedge clk);
        if (!m_busy) begin
            if (v) begin
                m_busy = 1'b1;
                m_word = d;
                m_pos  = 0;
            end
        end else if (!st) begin
            if (m_pos < 11) begin
                m_pos++;
            end else if (v) begin
                m_word = d;
                m_pos  = 0;
            end else begin
                m_busy = 1'b0;
            end
        end
    endtask

    task automatic send(input logic [11:0] d);
        step(1'b1, d, 1'b0);
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 12'h000, 1'b0);
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_err  = 0;
        m_busy = 1'b0;
        m_word = '0;
        m_pos  = 0;
        a0     = '0;
        a1     = '0;
        rst    = 1'b0;
        drive(1'b0, 12'h000, 1'b0);
        #2;
        check_outs(1'b0);
        @(negedge clk);
        rst = 1'b1;

        send(12'hA5C);
        send(12'h801);
        step(1'b0, 12'h000, 1'b1);

        // back-to-back with in_valid held high
        step(1'b1, 12'hFFF, 1'b0);
        for (int i = 0; i < 11; i++) begin
            step(1'b1, 12'h3C3, 1'b0);
        end
        step(1'b1, 12'h000, 1'b0);
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 12'h000, 1'b0);
        end

        // stall at position 5, then at position 11
        step(1'b1, 12'h6B1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 12'h000, 1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 12'hABC, 1'b1);
        end
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 12'h000, 1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 12'h555, 1'b1);
        end
        step(1'b0, 12'h000, 1'b0);

        // asynchronous reset between edges at position 7
        step(1'b1, 12'hD27, 1'b0);
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 12'h000, 1'b0);
        end
        drive(1'b0, 12'h000, 1'b0);
        #3;
        rst = 1'b0;
        #1;
        m_busy = 1'b0;
        m_pos  = 0;
        check_outs(1'b0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 12'h000, 1'b0);
        end

        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 3) != 0), 12'($urandom),
                 1'($urandom_range(0, 9) < 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
